// File: rtl/apu_pkg.sv
// apu_pkg: shared definitions for the APU pulse register front end.
//   - register offsets (relative to $4000) decoded by apu_reg_frame
//   - frame-sequencer mode and step enums
//   - default clocks-per-step for the frame sequencer
//   - helpers describing which ticks each sequencer step produces
package apu_pkg;

  localparam logic [4:0] ADDR_P1_BASE = 5'h00;
  localparam logic [4:0] ADDR_P2_BASE = 5'h04;
  localparam logic [4:0] ADDR_STATUS  = 5'h15;
  localparam logic [4:0] ADDR_FRAME   = 5'h17;

  localparam int DEFAULT_STEP_PERIOD = 3729;

  typedef enum logic {
    FRAME_4STEP = 1'b0,
    FRAME_5STEP = 1'b1
  } frame_mode_t;

  typedef enum logic [2:0] {
    STEP_0 = 3'd0,
    STEP_1 = 3'd1,
    STEP_2 = 3'd2,
    STEP_3 = 3'd3,
    STEP_4 = 3'd4
  } frame_step_t;

  // 5-step mode skips the quarter-frame on step 3; 4-step ticks on every step.
  function automatic logic step_has_qframe(frame_mode_t mode, frame_step_t step);
    return !((mode == FRAME_5STEP) && (step == STEP_3));
  endfunction

  function automatic logic step_has_hframe(frame_mode_t mode, frame_step_t step);
    if (mode == FRAME_4STEP) return (step == STEP_1) || (step == STEP_3);
    return (step == STEP_1) || (step == STEP_4);
  endfunction

  function automatic frame_step_t step_next(frame_mode_t mode, frame_step_t step);
    frame_step_t last;
    last = (mode == FRAME_4STEP) ? STEP_3 : STEP_4;
    if (step >= last) return STEP_0;
    return frame_step_t'(step + 3'd1);
  endfunction

endpackage

// File: rtl/apu_frame_seq.sv
// apu_frame_seq: APU frame sequencer.
//   Divider counts 0..STEP_PERIOD-1; each wrap fires the current step's
//   quarter/half-frame ticks one cycle later and advances the step.
//   Optional frame IRQ flag controlled by macro APU_FRAME_IRQ_EN; when the
//   macro is undefined frame_irq is tied low and inhibit/read-clear inputs
//   are ignored.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   frame_wr        $4017 write this cycle
//   mode_bit        $4017 data bit 7 (1 = 5-step)
//   inhibit_bit     $4017 data bit 6 (IRQ inhibit)
//   status_rd       $4015 read this cycle (clears IRQ flag)
//   qframe_tick     one-cycle quarter-frame tick
//   hframe_tick     one-cycle half-frame tick
//   frame_irq       frame interrupt flag (level)
//
// step   | meaning
// STEP_0 | first quarter; q (both modes)
// STEP_1 | q + h (both modes)
// STEP_2 | q (both modes)
// STEP_3 | 4-step: q + h + IRQ, wraps; 5-step: idle step
// STEP_4 | 5-step only: q + h, wraps
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int STEP_PERIOD = DEFAULT_STEP_PERIOD  // must be >= 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_wr,
  input  logic mode_bit,
  input  logic inhibit_bit,
  input  logic status_rd,
  output logic qframe_tick,
  output logic hframe_tick,
  output logic frame_irq
);

  localparam int DIV_W = $clog2(STEP_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_PERIOD - 1);

  frame_mode_t      mode;
  frame_step_t      step;
  logic [DIV_W-1:0] divider;
  logic             wrap;

  // A $4017 write restarts the sequencer and swallows a coincident wrap.
  assign wrap = !frame_wr && (divider == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= FRAME_4STEP;
      step        <= STEP_0;
      divider     <= '0;
      qframe_tick <= 1'b0;
      hframe_tick <= 1'b0;
    end else begin
      qframe_tick <= 1'b0;
      hframe_tick <= 1'b0;
      if (frame_wr) begin
        mode        <= frame_mode_t'(mode_bit);
        step        <= STEP_0;
        divider     <= '0;
        // entering 5-step mode clocks the channels immediately
        qframe_tick <= mode_bit;
        hframe_tick <= mode_bit;
      end else if (wrap) begin
        divider     <= '0;
        qframe_tick <= step_has_qframe(mode, step);
        hframe_tick <= step_has_hframe(mode, step);
        step        <= step_next(mode, step);
      end else begin
        divider <= divider + 1'b1;
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic irq_inhibit;
  logic irq_set;

  assign irq_set = wrap && (mode == FRAME_4STEP) && (step == STEP_3) && !irq_inhibit;

  // Set beats a same-cycle status read; the read still returns the old flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_inhibit <= 1'b0;
      frame_irq   <= 1'b0;
    end else if (frame_wr) begin
      irq_inhibit <= inhibit_bit;
      if (inhibit_bit || status_rd) frame_irq <= 1'b0;
    end else if (irq_set) begin
      frame_irq <= 1'b1;
    end else if (status_rd) begin
      frame_irq <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = inhibit_bit ^ status_rd;
  assign frame_irq = 1'b0;
`endif

endmodule

// File: rtl/apu_reg_frame.sv
// apu_reg_frame: CPU-facing front end for the APU pulse channels.
//   Decodes writes to $4000-$4007 (pulse images), $4015 (channel enables)
//   and $4017 (frame counter), reads of $4015 (status), issues one-cycle
//   side-effect strobes, and hosts the frame sequencer.
//   Optional feature macro: APU_FRAME_IRQ_EN (frame IRQ flag, inhibit and
//   read-clear); undefined -> frame_irq = 0 and rdata[6] = 0.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en, rd_en               single-cycle write / read strobes
//   addr[4:0], wdata[7:0]      offset from $4000, write data
//   len_nz[1:0]                length-counter-nonzero (bit1 = p2, bit0 = p1)
//   rdata[7:0]                 registered read data
//   p1_r0..p1_r3, p2_r0..p2_r3 pulse register images
//   ch_en[1:0]                 channel enables
//   p1/p2_sweep_stb            write to $4001/$4005
//   p1/p2_len_stb              write to $4003/$4007
//   qframe_tick, hframe_tick   frame-sequencer ticks
//   frame_irq                  frame interrupt flag
module apu_reg_frame
  import apu_pkg::*;
#(
  parameter int STEP_PERIOD = DEFAULT_STEP_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  input  logic [1:0] len_nz,
  output logic [7:0] rdata,
  output logic [7:0] p1_r0,
  output logic [7:0] p1_r1,
  output logic [7:0] p1_r2,
  output logic [7:0] p1_r3,
  output logic [7:0] p2_r0,
  output logic [7:0] p2_r1,
  output logic [7:0] p2_r2,
  output logic [7:0] p2_r3,
  output logic [1:0] ch_en,
  output logic       p1_sweep_stb,
  output logic       p2_sweep_stb,
  output logic       p1_len_stb,
  output logic       p2_len_stb,
  output logic       qframe_tick,
  output logic       hframe_tick,
  output logic       frame_irq
);

  logic p1_sel;
  logic p2_sel;
  logic frame_wr;
  logic status_rd;

  assign p1_sel    = wr_en && (addr[4:2] == ADDR_P1_BASE[4:2]);
  assign p2_sel    = wr_en && (addr[4:2] == ADDR_P2_BASE[4:2]);
  assign frame_wr  = wr_en && (addr == ADDR_FRAME);
  assign status_rd = rd_en && (addr == ADDR_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_r0 <= '0;
      p1_r1 <= '0;
      p1_r2 <= '0;
      p1_r3 <= '0;
      p2_r0 <= '0;
      p2_r1 <= '0;
      p2_r2 <= '0;
      p2_r3 <= '0;
      ch_en <= '0;
    end else begin
      if (p1_sel) begin
        case (addr[1:0])
          2'd0: p1_r0 <= wdata;
          2'd1: p1_r1 <= wdata;
          2'd2: p1_r2 <= wdata;
          2'd3: p1_r3 <= wdata;
        endcase
      end
      if (p2_sel) begin
        case (addr[1:0])
          2'd0: p2_r0 <= wdata;
          2'd1: p2_r1 <= wdata;
          2'd2: p2_r2 <= wdata;
          2'd3: p2_r3 <= wdata;
        endcase
      end
      if (wr_en && (addr == ADDR_STATUS)) ch_en <= wdata[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_sweep_stb <= 1'b0;
      p2_sweep_stb <= 1'b0;
      p1_len_stb   <= 1'b0;
      p2_len_stb   <= 1'b0;
    end else begin
      p1_sweep_stb <= wr_en && (addr == ADDR_P1_BASE + 5'd1);
      p2_sweep_stb <= wr_en && (addr == ADDR_P2_BASE + 5'd1);
      p1_len_stb   <= wr_en && (addr == ADDR_P1_BASE + 5'd3);
      p2_len_stb   <= wr_en && (addr == ADDR_P2_BASE + 5'd3);
    end
  end

  // frame_irq is sampled before this edge's read-clear, so the read sees the old flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= (addr == ADDR_STATUS) ? {1'b0, frame_irq, 4'b0000, len_nz} : 8'h00;
    end
  end

  apu_frame_seq #(
    .STEP_PERIOD (STEP_PERIOD)
  ) u_frame_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_wr    (frame_wr),
    .mode_bit    (wdata[7]),
    .inhibit_bit (wdata[6]),
    .status_rd   (status_rd),
    .qframe_tick (qframe_tick),
    .hframe_tick (hframe_tick),
    .frame_irq   (frame_irq)
  );

endmodule

// File: tb/tb_apu_reg_frame.sv
// Testbench for apu_reg_frame: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural
// model that tracks clocks elapsed since the last sequencer restart.
module tb_apu_reg_frame;

  localparam int P = 8;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [1:0] len_nz;
  logic [7:0] rdata;
  logic [7:0] p1_r0, p1_r1, p1_r2, p1_r3, p2_r0, p2_r1, p2_r2, p2_r3;
  logic [1:0] ch_en;
  logic       p1_sweep_stb, p2_sweep_stb, p1_len_stb, p2_len_stb;
  logic       qframe_tick, hframe_tick, frame_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apu_reg_frame #(.STEP_PERIOD(P)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .len_nz(len_nz), .rdata(rdata),
    .p1_r0(p1_r0), .p1_r1(p1_r1), .p1_r2(p1_r2), .p1_r3(p1_r3),
    .p2_r0(p2_r0), .p2_r1(p2_r1), .p2_r2(p2_r2), .p2_r3(p2_r3),
    .ch_en(ch_en), .p1_sweep_stb(p1_sweep_stb), .p2_sweep_stb(p2_sweep_stb),
    .p1_len_stb(p1_len_stb), .p2_len_stb(p2_len_stb),
    .qframe_tick(qframe_tick), .hframe_tick(hframe_tick), .frame_irq(frame_irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_img [8];
  logic [1:0]  m_en;
  logic [7:0]  m_rd;
  bit          m_sw1, m_sw2, m_len1, m_len2, m_q, m_h, m_irq;
  bit          m_five, m_inh;
  int unsigned since;   // clocks since reset release or last $4017 write

  function automatic bit q_at(bit five, int s);
    return five ? (s != 3) : 1'b1;
  endfunction

  function automatic bit h_at(bit five, int s);
    return five ? (s == 1 || s == 4) : (s == 1 || s == 3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_img[i] = 8'h00;
      m_en = 2'b00; m_rd = 8'h00;
      {m_sw1, m_sw2, m_len1, m_len2, m_q, m_h, m_irq} = '0;
      m_five = 1'b0; m_inh = 1'b0; since = 0;
    end else begin
      bit old_irq, set_irq, st_rd;
      int s;
      old_irq = m_irq;
      st_rd   = rd_en && (addr == 5'h15);
      {m_sw1, m_sw2, m_len1, m_len2, m_q, m_h} = '0;
      if (rd_en) m_rd = st_rd ? {1'b0, old_irq, 4'b0000, len_nz} : 8'h00;
      if (wr_en) begin
        if (addr < 5'd8) m_img[addr[2:0]] = wdata;
        if (addr == 5'h15) m_en = wdata[1:0];
        m_sw1  = (addr == 5'd1);
        m_sw2  = (addr == 5'd5);
        m_len1 = (addr == 5'd3);
        m_len2 = (addr == 5'd7);
      end
      if (wr_en && addr == 5'h17) begin
        m_five = wdata[7];
        since  = 0;
        m_q    = wdata[7];
        m_h    = wdata[7];
        if (IRQ_EN) begin
          m_inh = wdata[6];
          if (wdata[6]) m_irq = 1'b0;
        end
      end else begin
        since++;
        set_irq = 1'b0;
        if (since % P == 0) begin
          s   = int'((since / P - 1) % (m_five ? 5 : 4));
          m_q = q_at(m_five, s);
          m_h = h_at(m_five, s);
          set_irq = IRQ_EN && !m_five && (s == 3) && !m_inh;
        end
        if (set_irq) m_irq = 1'b1;
        else if (st_rd) m_irq = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("p1_r0", p1_r0, m_img[0]);
    chk("p1_r1", p1_r1, m_img[1]);
    chk("p1_r2", p1_r2, m_img[2]);
    chk("p1_r3", p1_r3, m_img[3]);
    chk("p2_r0", p2_r0, m_img[4]);
    chk("p2_r1", p2_r1, m_img[5]);
    chk("p2_r2", p2_r2, m_img[6]);
    chk("p2_r3", p2_r3, m_img[7]);
    chk("ch_en", ch_en, m_en);
    chk("rdata", rdata, m_rd);
    chk("strobes", {p1_sweep_stb, p2_sweep_stb, p1_len_stb, p2_len_stb},
        {m_sw1, m_sw2, m_len1, m_len2});
    chk("qframe_tick", qframe_tick, m_q);
    chk("hframe_tick", hframe_tick, m_h);
    chk("frame_irq", frame_irq, m_irq);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int qn, hn, qfirst, qlast, h1, h2, pos;
    logic [4:0] qmask, hmask;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; len_nz = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_images", {p1_r0, p1_r1, p1_r2, p1_r3, p2_r0}, 40'h0);
    chk("rst_misc", {rdata, ch_en, qframe_tick, hframe_tick, frame_irq}, 13'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4-step free run
    qn = 0; hn = 0; qfirst = 0; qlast = 0; h1 = 0; h2 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (qframe_tick) begin qn++; if (qn == 1) qfirst = i; qlast = i; end
      if (hframe_tick) begin hn++; if (hn == 1) h1 = i; else h2 = i; end
    end
    #1;
    chk("t4_qcount", qn, 4);
    chk("t4_qfirst", qfirst, P);
    chk("t4_qlast", qlast, 4 * P);
    chk("t4_hcount", hn, 2);
    chk("t4_hpos", {h1[15:0], h2[15:0]}, {16'(2 * P), 16'(4 * P)});
    chk("t4_irq", frame_irq, IRQ_EN);

    // status read and read-clear
    len_nz = 2'b01;
    rd(5'h15); #1;
    chk("rd1_rdata", rdata, IRQ_EN ? 8'h41 : 8'h01);
    chk("rd1_irq", frame_irq, 0);
    rd(5'h15); #1;
    chk("rd2_rdata", rdata, 8'h01);
    rd(5'h10); #1;
    chk("rd_other", rdata, 8'h00);

    // pulse-1 writes
    wr(5'h00, 8'hBF); #1;
    chk("w4000", p1_r0, 8'hBF);
    wr(5'h03, 8'h08); #1;
    chk("w4003", p1_r3, 8'h08);
    chk("len_stb_hi", p1_len_stb, 1);
    idle(1); #1;
    chk("len_stb_lo", p1_len_stb, 0);
    chk("p2_zero", {p2_r0, p2_r1, p2_r2, p2_r3}, 32'h0);

    // 5-step entry mid-step
    idle(3);
    wr(5'h17, 8'h80); #1;
    chk("t5_imm", {qframe_tick, hframe_tick}, 2'b11);
    qmask = '0; hmask = '0; qn = 0;
    for (int i = 1; i <= 5 * P; i++) begin
      @(negedge clk);
      if (qframe_tick) begin qn++; qmask[(i - 1) / P] = 1'b1; end
      if (hframe_tick) hmask[(i - 1) / P] = 1'b1;
    end
    #1;
    chk("t5_qcount", qn, 4);
    chk("t5_qmask", qmask, 5'b10111);
    chk("t5_hmask", hmask, 5'b10010);
    chk("t5_irq", frame_irq, 0);

    // inhibit clears a pending IRQ and blocks new ones
    wr(5'h17, 8'h00);
    idle(4 * P); #1;
    chk("inh_pre", frame_irq, IRQ_EN);
    wr(5'h17, 8'h40); #1;
    chk("inh_clr", frame_irq, 0);
    qn = 0;
    for (int i = 1; i <= 4 * P + 2; i++) begin
      @(negedge clk);
      if (qframe_tick) qn++;
      if (frame_irq) pos = i;
    end
    #1;
    chk("inh_qcount", qn, 4);
    chk("inh_irq", frame_irq, 0);

    // $4017 write on the wrap edge suppresses that step's tick
    wr(5'h17, 8'h00);
    idle(P - 1);
    wr(5'h17, 8'h00); #1;
    chk("wrap_wr_tick", qframe_tick, 0);
    idle(P - 1); #1;
    chk("wrap_early", qframe_tick, 0);
    idle(1); #1;
    chk("wrap_next", qframe_tick, 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en  = ($urandom_range(0, 99) < 35);
      rd_en  = ($urandom_range(0, 9) == 0);
      addr   = 5'($urandom_range(0, 22));
      wdata  = 8'($urandom);
      len_nz = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        wr_en = 1'b1;
        addr  = 5'h17;
      end
      @(negedge clk);
    end
    idle(1);

    // mid-sequence reset
    wr(5'h15, 8'h03);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_en", ch_en, 2'b00);
    chk("mrst_img", {p1_r0, p1_r1, p1_r2, p1_r3, p2_r0, p2_r1, p2_r2, p2_r3}, 64'h0);
    chk("mrst_misc", {rdata, qframe_tick, hframe_tick, frame_irq,
                      p1_sweep_stb, p2_sweep_stb, p1_len_stb, p2_len_stb}, 15'h0);
    idle(2);
    rst_n = 1'b1;
    pos = 0;
    for (int i = 1; i <= 3 * P; i++) begin
      @(negedge clk);
      if (qframe_tick) begin pos = i; break; end
    end
    #1;
    chk("mrst_first_q", pos, P);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
